ege_bit_encoder: RTL and testbench

Exp-Golomb bitstream encoder, the transmit-side counterpart of the exp-Golomb decoder core in the H.264 user project. It takes one ue(v) or se(v) syntax element per handshake and serializes the codeword MSB-first, one bit per clock. It runs on the Wishbone clock inside the user project area. Its job is to generate loopback stimulus for the decoder and to drive a bit-serial stream out to the logic analyzer.

---
 rtl/ege_pkg.sv | 38 +++
 rtl/ege_lzc.sv | 19 +
 rtl/ege_bit_encoder.sv | 142 ++++++++++++++
 tb/tb_ege_bit_encoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ege_pkg.sv
// Shared types, widths and the ue/se mapping for the exp-Golomb bit encoder.
// EGE_DATA_W is the syntax-element width. The top-level DATA_W parameter must
// keep this value because ege_map is sized from it.
package ege_pkg;

  localparam int EGE_DATA_W = 16;
  // Bits needed to index any position of the (DATA_W+1)-bit codeword value.
  localparam int EGE_IDX_W  = $clog2(EGE_DATA_W + 1);
  // Width of the prefix/suffix down-counter and of the leading-one index.
  localparam int EGE_CNT_W  = EGE_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2
  } ege_state_e;

  // Map a syntax element to codeNum k. ue passes v through unchanged.
  // se maps v>0 to 2v-1 and v<=0 to -2v. All arithmetic is done in
  // DATA_W+1 bits, so the most negative v lands exactly on 2^DATA_W.
  function automatic logic [EGE_DATA_W:0] ege_map(input logic [EGE_DATA_W-1:0] v,
                                                  input logic is_se);
    logic [EGE_DATA_W:0] vx;
    logic [EGE_DATA_W:0] v2;
    logic [EGE_DATA_W:0] k;
    vx = {v[EGE_DATA_W-1], v};
    v2 = {vx[EGE_DATA_W-1:0], 1'b0};
    if (!is_se) begin
      k = {1'b0, v};
    end else if (!v[EGE_DATA_W-1] && (v != '0)) begin
      k = v2 - {{EGE_DATA_W{1'b0}}, 1'b1};
    end else begin
      k = '0 - v2;
    end
    return k;
  endfunction

endpackage

// File: rtl/ege_lzc.sv
// Leading-one detector: returns the index of the most significant set bit of
// x_i. Returns 0 for x_i == 0, which the encoder never presents.
module ege_lzc #(
  parameter int W  = 17,
  parameter int NW = 6
) (
  input  logic [W-1:0]  x_i,
  output logic [NW-1:0] n_o
);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    n_o = '0;
    for (int i = 0; i < W; i++) begin
      if (x_i[i]) n_o = NW'(i);
    end
  end

endmodule

// File: rtl/ege_bit_encoder.sv
// Exp-Golomb bit-serial encoder: accepts one ue(v)/se(v) element per
// handshake and emits N zeros followed by x[N:0] MSB-first, x = k+1.
// Build option: define EGE_SE_EN to compile in the se(v) mapping selected by
// in_signed. Without it in_signed is ignored and every element is ue(v).
//
// state  | meaning
// IDLE   | no codeword loaded, ready for a new element
// PREFIX | emitting the N leading zeros, cnt counts N..1
// SUFFIX | emitting x[cnt], cnt counts N..0, last bit at cnt==0
module ege_bit_encoder
  import ege_pkg::*;
#(
  parameter int DATA_W = EGE_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_signed,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_last,
  output logic [15:0]       cw_count
);

  localparam int XW = DATA_W + 1;

  ege_state_e           state_q, state_d;
  logic [EGE_CNT_W-1:0] cnt_q, cnt_d;
  logic [EGE_CNT_W-1:0] n_q, n_d;
  logic [XW-1:0]        x_q, x_d;
  logic [15:0]          cw_count_q, cw_count_d;

  logic [XW-1:0]        k_map;
  logic [XW-1:0]        x_new;
  logic [EGE_CNT_W-1:0] n_new;
  ege_state_e           load_state;
  logic                 fire;
  logic                 last_fire;
  logic                 accept;

`ifdef EGE_SE_EN
  assign k_map = ege_map(in_data, in_signed);
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign k_map = {1'b0, in_data};
`endif

  assign x_new = k_map + XW'(1);

  ege_lzc #(
    .W  (XW),
    .NW (EGE_CNT_W)
  ) u_lzc (
    .x_i (x_new),
    .n_o (n_new)
  );

  // A single-bit codeword (k=0) skips the prefix entirely.
  assign load_state = (n_new == '0) ? SUFFIX : PREFIX;

  // Outputs decode straight from registers so they hold steady under stall.
  assign bit_valid = (state_q != IDLE);
  assign bit_last  = (state_q == SUFFIX) && (cnt_q == '0);
  assign bit_out   = (state_q == SUFFIX) && x_q[cnt_q[EGE_IDX_W-1:0]];
  assign cw_count  = cw_count_q;

  assign fire      = bit_valid && bit_ready;
  assign last_fire = fire && bit_last;
  // Ready while idle, or in the cycle the final bit drains, so codewords
  // can follow each other with no gap.
  assign in_ready  = !wb_rst_i && ((state_q == IDLE) || last_fire);
  assign accept    = in_valid && in_ready;

  // Next-state logic: load on accept, count down on each consumed bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    x_d        = x_q;
    cw_count_d = cw_count_q;
    if (last_fire) cw_count_d = cw_count_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = load_state;
          cnt_d   = n_new;
          n_d     = n_new;
          x_d     = x_new;
        end
      end
      PREFIX: begin
        if (fire) begin
          if (cnt_q == EGE_CNT_W'(1)) begin
            state_d = SUFFIX;
            cnt_d   = n_q;
          end else begin
            cnt_d = cnt_q - EGE_CNT_W'(1);
          end
        end
      end
      SUFFIX: begin
        if (fire) begin
          if (cnt_q == '0) begin
            if (accept) begin
              state_d = load_state;
              cnt_d   = n_new;
              n_d     = n_new;
              x_d     = x_new;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - EGE_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial codeword.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      x_q        <= '0;
      cw_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      x_q        <= x_d;
      cw_count_q <= cw_count_d;
    end
  end

endmodule

// File: tb/tb_ege_bit_encoder.sv
module tb_ege_bit_encoder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_out;
  logic        bit_last;
  logic [15:0] cw_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cw = 16'd0;

  always #5 wb_clk_i = ~wb_clk_i;

  ege_bit_encoder #(.DATA_W(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_last  (bit_last),
    .cw_count  (cw_count)
  );

  task automatic step;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_signed = 1'b0; bit_ready = 1'b1;
    step;
    step;
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
    checks++;
    if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got %b want 0", bit_out); end
    checks++;
    if (bit_last !== 1'b0) begin errors++; $display("FAIL reset_bit_last got %b want 0", bit_last); end
    checks++;
    if (cw_count !== 16'd0) begin errors++; $display("FAIL reset_cw_count got %0d want 0", cw_count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    wb_rst_i = 1'b0;
    step;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  // Send one element under constant bit_ready and compare the whole codeword.
  task automatic run_cw(input string name, input logic [15:0] d, input logic s,
                        input int exp_len, input logic [32:0] exp_bits);
    logic [32:0] got;
    int          n;
    bit          last_bad;
    bit          done;
    got = '0; n = 0; last_bad = 1'b0; done = 1'b0;
    bit_ready = 1'b1; in_data = d; in_signed = s; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready got %b want 1", name, in_ready); end
    step;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    in_signed = 1'($urandom);
    checks++;
    if (bit_valid !== 1'b1) begin errors++; $display("FAIL %s_latency bit_valid got %b want 1", name, bit_valid); end
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        if (bit_valid !== 1'b1) begin
          done = 1'b1;
        end else begin
          got = {got[31:0], bit_out};
          if (bit_last !== ((n == exp_len - 1) ? 1'b1 : 1'b0)) last_bad = 1'b1;
          n++;
          if (bit_last === 1'b1) done = 1'b1;
          step;
        end
      end
    end
    checks++;
    if (n != exp_len) begin errors++; $display("FAIL %s_length got %0d want %0d", name, n, exp_len); end
    checks++;
    if (got !== exp_bits) begin errors++; $display("FAIL %s_bits got %h want %h", name, got, exp_bits); end
    checks++;
    if (last_bad) begin errors++; $display("FAIL %s_bit_last got misplaced want only on bit %0d", name, exp_len - 1); end
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL %s_idle_after got bit_valid=%b want 0", name, bit_valid); end
    exp_cw = exp_cw + 16'd1;
    checks++;
    if (cw_count !== exp_cw) begin errors++; $display("FAIL %s_cw_count got %0d want %0d", name, cw_count, exp_cw); end
  endtask

  task automatic test_ue_basic;
    run_cw("ue_k0", 16'd0, 1'b0, 1, 33'h1);
    run_cw("ue_k3", 16'd3, 1'b0, 5, 33'h4);
  endtask

  task automatic test_mapping;
`ifdef EGE_SE_EN
    run_cw("se_p1", 16'd1, 1'b1, 3, 33'h2);
    run_cw("se_m2", 16'hFFFE, 1'b1, 5, 33'h5);
`else
    run_cw("nose_fffe", 16'hFFFE, 1'b1, 31, 33'h0_0000_FFFF);
`endif
  endtask

  task automatic test_max;
    run_cw("ue_max", 16'hFFFF, 1'b0, 33, 33'h0_0001_0000);
`ifdef EGE_SE_EN
    run_cw("se_min", 16'h8000, 1'b1, 33, 33'h0_0001_0001);
`endif
  endtask

  task automatic test_back_to_back;
    logic [5:0] bits;
    logic [5:0] rdy;
    bit         gap;
    bit         acc;
    bits = '0; rdy = '0; gap = 1'b0;
    bit_ready = 1'b1; in_signed = 1'b0; in_data = 16'd1; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept in_ready got %b want 1", in_ready); end
    step;
    in_data = 16'd2;
    for (int c = 0; c < 6; c++) begin
      if (bit_valid !== 1'b1) gap = 1'b1;
      bits = {bits[4:0], bit_out};
      rdy  = {rdy[4:0], in_ready};
      acc  = in_ready && in_valid;
      step;
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (gap) begin errors++; $display("FAIL b2b_gap got bit_valid low want continuous"); end
    checks++;
    if (bits !== 6'b010011) begin errors++; $display("FAIL b2b_bits got %b want 010011", bits); end
    checks++;
    if (rdy !== 6'b001001) begin errors++; $display("FAIL b2b_in_ready got %b want 001001", rdy); end
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_after got %b want 0", bit_valid); end
    exp_cw = exp_cw + 16'd2;
    checks++;
    if (cw_count !== exp_cw) begin errors++; $display("FAIL b2b_cw_count got %0d want %0d", cw_count, exp_cw); end
  endtask

  // ue k=20 -> x=21 -> "000010101"; throttle, then reset while bit 3 is shown.
  task automatic test_throttle_reset;
    logic [8:0] exp9;
    int         consumed;
    logic       held_o;
    logic       held_l;
    logic       r;
    bit         reappear;
    exp9 = 9'b000010101;
    consumed = 0; reappear = 1'b0;
    bit_ready = 1'b0; in_signed = 1'b0; in_data = 16'd20; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    in_data = 16'hBEEF;
    for (int c = 0; c < 200; c++) begin
      if (consumed < 3) begin
        held_o = bit_out;
        held_l = bit_last;
        r = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        bit_ready = r;
        step;
        checks++;
        if (!r) begin
          if (bit_valid !== 1'b1 || bit_out !== held_o || bit_last !== held_l) begin
            errors++;
            $display("FAIL stall_hold got v=%b o=%b l=%b want v=1 o=%b l=%b", bit_valid, bit_out, bit_last, held_o, held_l);
          end
        end else begin
          if (held_o !== exp9[8 - consumed] || held_l !== 1'b0) begin
            errors++;
            $display("FAIL throttle_bit%0d got o=%b l=%b want o=%b l=0", consumed, held_o, held_l, exp9[8 - consumed]);
          end
          consumed++;
        end
      end
    end
    checks++;
    if (consumed != 3) begin errors++; $display("FAIL throttle_timeout got %0d bits want 3", consumed); end
    wb_rst_i = 1'b1;
    bit_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    step;
    wb_rst_i = 1'b0;
    checks++;
    if (bit_valid !== 1'b0) begin errors++; $display("FAIL rst_bit_valid got %b want 0", bit_valid); end
    checks++;
    if (cw_count !== 16'd0) begin errors++; $display("FAIL rst_cw_count got %0d want 0", cw_count); end
    exp_cw = 16'd0;
    for (int c = 0; c < 5; c++) begin
      if (bit_valid !== 1'b0) reappear = 1'b1;
      step;
    end
    checks++;
    if (reappear) begin errors++; $display("FAIL rst_reappear got bit_valid high want 0"); end
    run_cw("post_rst_k3", 16'd3, 1'b0, 5, 33'h4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ue_basic;
    test_mapping;
    test_max;
    test_back_to_back;
    test_throttle_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
